// File: rtl/gpu_dma_pkg.sv
// Shared definitions for the GPU DMA reader/writer pair:
// FSM encodings, AXI constants and the 4 KB crossing check.
package gpu_dma_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CHECK = 3'd1;
   localparam logic [2:0] ST_ADDR  = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERROR = 3'd5;
   localparam logic [2:0] ST_FLUSH = 3'd6;

   localparam logic [2:0]  SIZE_4B    = 3'b010;
   localparam logic [1:0]  BURST_INCR = 2'b01;
   localparam logic [1:0]  RESP_OKAY  = 2'b00;

   localparam logic [12:0] BOUNDARY_4K = 13'd4096;

   // Caller guarantees len <= 256, so the 13-bit sum cannot wrap.
   function automatic logic crosses_4k(
      input logic [11:0] addr_lo,
      input logic [10:0] len_lo
   );
      logic [12:0] end_off;
      end_off = {1'b0, addr_lo} + {len_lo, 2'b00};
      return end_off > BOUNDARY_4K;
   endfunction

endpackage

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master: fetches one INCR burst of 32-bit words
// and pushes each beat into the GPU data FIFO.
module painterengine_gpu_dma_reader
   import gpu_dma_pkg::*;
#(
   parameter int MAX_BURST = 32
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_resetn,
   input  logic        i_wire_ctrl_resetn,
   input  logic [31:0] i_wire_address,
   input  logic [31:0] i_wire_length,
   output logic        o_wire_done,
   output logic        o_wire_error,
   output logic [31:0] o_wire_axi_araddr,
   output logic [7:0]  o_wire_axi_arlen,
   output logic [2:0]  o_wire_axi_arsize,
   output logic [1:0]  o_wire_axi_arburst,
   output logic        o_wire_axi_arvalid,
   input  logic        i_wire_axi_arready,
   input  logic [31:0] i_wire_axi_rdata,
   input  logic [1:0]  i_wire_axi_rresp,
   input  logic        i_wire_axi_rlast,
   input  logic        i_wire_axi_rvalid,
   output logic        o_wire_axi_rready,
   output logic [31:0] o_wire_fifo_wdata,
   output logic        o_wire_fifo_wen,
   input  logic        i_wire_fifo_full
);

   logic [2:0]  state_q;
   logic [31:0] addr_q;
   logic [31:0] len_q;
   logic [8:0]  cnt_q;
   logic        resp_err_q;
   logic        over_q;
   logic        ar_acc_q;

   logic        arvalid;
   logic        rready;
   logic        r_hs;
   logic        ar_hs;
   logic [8:0]  beat_next;
   logic        last_beat;
   logic        beat_bad;

   always_comb begin
      arvalid = (state_q == ST_ADDR) ||
                ((state_q == ST_FLUSH) && !ar_acc_q);
      rready  = 1'b0;
      if (state_q == ST_DATA)
         rready = over_q || !i_wire_fifo_full;
      else if (state_q == ST_FLUSH)
         rready = ar_acc_q;
      r_hs      = i_wire_axi_rvalid && rready;
      ar_hs     = arvalid && i_wire_axi_arready;
      beat_next = cnt_q + 9'd1;
      last_beat = (beat_next == len_q[8:0]);
      beat_bad  = (i_wire_axi_rresp != RESP_OKAY);
   end

   assign o_wire_axi_arvalid = arvalid;
   assign o_wire_axi_rready  = rready;
   assign o_wire_axi_arsize  = SIZE_4B;
   assign o_wire_axi_arburst = BURST_INCR;
   assign o_wire_axi_araddr  = arvalid ? addr_q : 32'd0;
   assign o_wire_axi_arlen   = arvalid ? (len_q[7:0] - 8'd1) : 8'd0;

   // Overrun beats (after beat N without rlast) are drained, not pushed.
   assign o_wire_fifo_wen   = (state_q == ST_DATA) && r_hs && !over_q;
   assign o_wire_fifo_wdata = o_wire_fifo_wen ? i_wire_axi_rdata : 32'd0;

   assign o_wire_done  = (state_q == ST_DONE);
   assign o_wire_error = (state_q == ST_ERROR);

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state_q    <= ST_IDLE;
         addr_q     <= 32'd0;
         len_q      <= 32'd0;
         cnt_q      <= 9'd0;
         resp_err_q <= 1'b0;
         over_q     <= 1'b0;
         ar_acc_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_wire_ctrl_resetn) begin
                  addr_q     <= i_wire_address;
                  len_q      <= i_wire_length;
                  cnt_q      <= 9'd0;
                  resp_err_q <= 1'b0;
                  over_q     <= 1'b0;
                  ar_acc_q   <= 1'b0;
                  state_q    <= (i_wire_length == 32'd0) ? ST_DONE
                                                         : ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!i_wire_ctrl_resetn)
                  state_q <= ST_IDLE;
               else if (len_q > 32'(MAX_BURST))
                  state_q <= ST_ERROR;
               else if (addr_q[1:0] != 2'b00)
                  state_q <= ST_ERROR;
               else if (crosses_4k(addr_q[11:0], len_q[10:0]))
                  state_q <= ST_ERROR;
               else
                  state_q <= ST_ADDR;
            end
            ST_ADDR: begin
               if (!i_wire_ctrl_resetn) begin
                  ar_acc_q <= i_wire_axi_arready;
                  state_q  <= ST_FLUSH;
               end else if (i_wire_axi_arready) begin
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (r_hs && !over_q) begin
                  cnt_q <= beat_next;
                  if (beat_bad)
                     resp_err_q <= 1'b1;
               end
               if (!i_wire_ctrl_resetn) begin
                  // A final beat taken this cycle closes the burst already.
                  ar_acc_q <= 1'b1;
                  state_q  <= (r_hs && i_wire_axi_rlast) ? ST_IDLE
                                                         : ST_FLUSH;
               end else if (r_hs) begin
                  if (over_q) begin
                     if (i_wire_axi_rlast)
                        state_q <= ST_ERROR;
                  end else if (i_wire_axi_rlast) begin
                     if (last_beat && !resp_err_q && !beat_bad)
                        state_q <= ST_DONE;
                     else
                        state_q <= ST_ERROR;
                  end else if (last_beat) begin
                     over_q <= 1'b1;
                  end
               end
            end
            ST_DONE, ST_ERROR: begin
               if (!i_wire_ctrl_resetn)
                  state_q <= ST_IDLE;
            end
            ST_FLUSH: begin
               if (ar_hs)
                  ar_acc_q <= 1'b1;
               if (r_hs && i_wire_axi_rlast)
                  state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for the DMA reader: table vectors, random transfers
// against a transfer-level model, and an abort sequence.
module tb_painterengine_gpu_dma_reader;

   localparam int MAXB = 32;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        ctrl = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] len = '0;
   logic        done, error;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rlast = 1'b0;
   logic        rvalid = 1'b0;
   logic        rready;
   logic [31:0] wdata;
   logic        wen;
   logic        full = 1'b0;

   painterengine_gpu_dma_reader #(.MAX_BURST(MAXB)) dut (
      .i_wire_clock       (clk),
      .i_wire_resetn      (rstn),
      .i_wire_ctrl_resetn (ctrl),
      .i_wire_address     (addr),
      .i_wire_length      (len),
      .o_wire_done        (done),
      .o_wire_error       (error),
      .o_wire_axi_araddr  (araddr),
      .o_wire_axi_arlen   (arlen),
      .o_wire_axi_arsize  (arsize),
      .o_wire_axi_arburst (arburst),
      .o_wire_axi_arvalid (arvalid),
      .i_wire_axi_arready (arready),
      .i_wire_axi_rdata   (rdata),
      .i_wire_axi_rresp   (rresp),
      .i_wire_axi_rlast   (rlast),
      .i_wire_axi_rvalid  (rvalid),
      .o_wire_axi_rready  (rready),
      .o_wire_fifo_wdata  (wdata),
      .o_wire_fifo_wen    (wen),
      .i_wire_fifo_full   (full)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // slave configuration
   int          cfg_fm = 0;
   int          cfg_gaps = 0;
   int          cfg_eb = 999;
   int          cfg_ovr = 0;
   logic [31:0] cfg_base = '0;

   // monitor state
   int          cyc = 0;
   bit          ar_hs_f = 0;
   bit          r_hs_f = 0;
   int          n_ar = 0;
   int          n_arv = 0;
   logic [31:0] ar_addr_seen = '0;
   logic [7:0]  ar_len_seen = '0;
   logic [31:0] wq[$];
   int          full_viol = 0;
   int          rlast_hs = 0;
   int          rlast_cyc = -1;
   bit          busy = 0;
   int          idx = 0;
   int          nbeats = 0;

   always @(posedge clk) begin
      cyc++;
      ar_hs_f = arvalid && arready;
      r_hs_f  = rvalid && rready;
      if (arvalid) n_arv++;
      if (ar_hs_f) begin
         n_ar++;
         ar_addr_seen = araddr;
         ar_len_seen  = arlen;
      end
      if (wen) begin
         if (full) full_viol++;
         wq.push_back(wdata);
      end
      if (r_hs_f && rlast) begin
         rlast_hs++;
         rlast_cyc = cyc;
      end
   end

   // AXI slave and FIFO-full driver, updated away from the active edge
   initial begin
      forever begin
         bit hold;
         @(negedge clk);
         hold = rvalid && !r_hs_f;
         if (ar_hs_f) begin
            busy = 1;
            idx = 0;
            nbeats = (cfg_ovr != 0) ? cfg_ovr : int'(ar_len_seen) + 1;
         end
         if (r_hs_f && busy) begin
            idx++;
            if (idx == nbeats) busy = 0;
         end
         arready = !busy && (cfg_gaps == 0 || $urandom_range(0, 1) == 1);
         if (busy) begin
            if (!hold) begin
               rvalid = (cfg_gaps == 0) || ($urandom_range(0, 1) == 1);
               rdata  = cfg_base + 32'(idx);
               rresp  = (idx == cfg_eb) ? 2'b10 : 2'b00;
               rlast  = (idx == nbeats - 1);
            end
         end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
         end
         case (cfg_fm)
            1: full = ~full;
            2: full = ($urandom_range(0, 2) == 0);
            3: full = 1'b1;
            default: full = 1'b0;
         endcase
      end
   end

   task automatic clear_mon();
      wq.delete();
      n_ar = 0;
      n_arv = 0;
      full_viol = 0;
      rlast_hs = 0;
      rlast_cyc = -1;
   endtask

   task automatic wait_idle_slave(input string nm);
      int i;
      for (i = 0; i < 300 && busy; i++) @(negedge clk);
      if (busy) chk({nm, "/slave_timeout"}, 1, 0);
      repeat (2) @(negedge clk);
   endtask

   // Transfer-level outcome derived from the block's acceptance rules.
   function automatic void model(input logic [31:0] a, input logic [31:0] l,
                                 input int eb, input int ovr,
                                 output int r, output int ea, output int nw);
      longint sent;
      longint endoff;
      endoff = longint'(a % 4096) + longint'(l) * 4;
      r = 2; ea = 0; nw = 0;
      if (l == 0) r = 1;
      else if (l > MAXB) r = 2;
      else if (a % 4 != 0) r = 2;
      else if (endoff > 4096) r = 2;
      else begin
         ea = 1;
         sent = (ovr != 0) ? ovr : l;
         nw = (sent < l) ? int'(sent) : int'(l);
         r = (sent != l || eb < int'(l)) ? 2 : 1;
      end
   endfunction

   task automatic run_and_check(input string nm, input logic [31:0] a,
                                input logic [31:0] l, input int fm,
                                input int gaps, input int eb, input int ovr,
                                input int er, input int ea, input int enw);
      int lat, fin, fin_cyc, res, derr;
      clear_mon();
      cfg_fm = fm; cfg_gaps = gaps; cfg_eb = eb; cfg_ovr = ovr;
      cfg_base = $urandom;
      @(negedge clk);
      addr = a; len = l; ctrl = 1'b1;
      lat = -1; fin = 0; fin_cyc = -1;
      for (int i = 1; i <= 2000 && fin == 0; i++) begin
         @(negedge clk);
         if (arvalid && lat < 0) lat = i;
         if (done || error) begin
            fin = i;
            fin_cyc = cyc;
         end
      end
      res = done ? 1 : (error ? 2 : 0);
      chk({nm, "/result"}, res, er);
      repeat (3) @(negedge clk);
      chk({nm, "/held"}, {done, error}, (er == 1) ? 2'b10 : 2'b01);
      if (ea != 0) begin
         chk({nm, "/ar_count"}, n_ar, 1);
         chk({nm, "/araddr"}, ar_addr_seen, a);
         chk({nm, "/arlen"}, ar_len_seen, 8'(l - 1));
         chk({nm, "/ar_latency"}, lat, 2);
      end else begin
         chk({nm, "/no_arvalid"}, n_arv, 0);
      end
      chk({nm, "/writes"}, wq.size(), enw);
      derr = 0;
      foreach (wq[i]) if (wq[i] !== cfg_base + 32'(i)) derr++;
      chk({nm, "/wdata"}, derr, 0);
      chk({nm, "/wen_while_full"}, full_viol, 0);
      if (enw > 0) chk({nm, "/flag_latency"}, fin_cyc - rlast_cyc, 0);
      ctrl = 1'b0;
      @(negedge clk);
      chk({nm, "/clear"}, {done, error}, 2'b00);
      wait_idle_slave(nm);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] l;
      int fm, gaps, eb, ovr;
      int er, ea, enw;
   } vec_t;

   vec_t tbl[13];

   initial begin
      bit seen;
      int n;
      tbl[0]  = '{32'h1000_0000, 32, 0, 0, 999, 0, 1, 1, 32};
      tbl[1]  = '{32'h2000_0100,  8, 1, 0, 999, 0, 1, 1, 8};
      tbl[2]  = '{32'h1000_0000, 33, 0, 0, 999, 0, 2, 0, 0};
      tbl[3]  = '{32'h0000_1002,  4, 0, 0, 999, 0, 2, 0, 0};
      tbl[4]  = '{32'h0000_0FF0,  8, 0, 0, 999, 0, 2, 0, 0};
      tbl[5]  = '{32'h4000_0000,  0, 0, 0, 999, 0, 1, 0, 0};
      tbl[6]  = '{32'h1000_0040,  4, 0, 0,   1, 0, 2, 1, 4};
      tbl[7]  = '{32'h1000_0080,  4, 0, 0, 999, 3, 2, 1, 3};
      tbl[8]  = '{32'h1000_00C0,  4, 2, 1, 999, 6, 2, 1, 4};
      tbl[9]  = '{32'h0000_0FF0,  4, 0, 0, 999, 0, 1, 1, 4};
      tbl[10] = '{32'h5000_0F80, 32, 2, 1, 999, 0, 1, 1, 32};
      tbl[11] = '{32'h6000_0000,  1, 0, 1, 999, 0, 1, 1, 1};
      tbl[12] = '{32'h7000_0001,  0, 0, 0, 999, 0, 1, 0, 0};

      repeat (3) @(negedge clk);
      chk("reset/flags", {done, error}, 2'b00);
      chk("reset/arvalid", arvalid, 0);
      chk("reset/araddr", araddr, 0);
      chk("reset/rready", rready, 0);
      chk("reset/wen", wen, 0);
      chk("reset/arsize", arsize, 3'b010);
      chk("reset/arburst", arburst, 2'b01);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      foreach (tbl[i])
         run_and_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].l,
                       tbl[i].fm, tbl[i].gaps, tbl[i].eb, tbl[i].ovr,
                       tbl[i].er, tbl[i].ea, tbl[i].enw);

      // abort after 5 beats: the rest must be drained without FIFO writes
      clear_mon();
      cfg_fm = 0; cfg_gaps = 0; cfg_eb = 999; cfg_ovr = 0;
      cfg_base = 32'hA500_0000;
      @(negedge clk);
      addr = 32'h3000_0000; len = 16; ctrl = 1'b1;
      n = 0;
      while (n < 300 && wq.size() < 5) begin
         @(negedge clk);
         n++;
      end
      chk("abort/reached5", wq.size(), 5);
      cfg_fm = 3; full = 1'b1; ctrl = 1'b0;
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done || error) seen = 1;
         if (i == 2) cfg_fm = 0;
         if (!busy && rlast_hs > 0) break;
      end
      repeat (3) begin
         @(negedge clk);
         if (done || error) seen = 1;
      end
      chk("abort/writes", wq.size(), 5);
      chk("abort/drained", rlast_hs, 1);
      chk("abort/no_flags", seen, 0);
      chk("abort/rready_idle", rready, 0);
      run_and_check("after_abort", 32'h3000_0000, 16, 0, 0, 999, 0, 1, 1, 16);

      for (int t = 0; t < 30; t++) begin
         logic [31:0] a, l;
         int eb, ovr, fm, gaps, er, ea, enw;
         a = {$urandom_range(0, 65535), 4'h0, 12'h000};
         a[11:0] = 12'($urandom_range(0, 4095));
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         l = $urandom_range(0, 40);
         eb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 40) : 999;
         ovr = ($urandom_range(0, 5) == 0) ? $urandom_range(1, int'(l) + 2) : 0;
         fm = $urandom_range(0, 2);
         gaps = $urandom_range(0, 1);
         model(a, l, eb, ovr, er, ea, enw);
         run_and_check($sformatf("rnd%0d", t), a, l, fm, gaps, eb, ovr,
                       er, ea, enw);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/painterengine_gpu_dma_reader.md
Name: painterengine_gpu_dma_reader

Overview:
- AXI4 read master that fetches one block of 32-bit words from system memory and pushes it into the GPU data FIFO.
- Started and stopped by a per-transfer control reset (ctrl_resetn) that the GPU task sequencer drives. It reports completion with level done/error flags.
- It sits between the sequencer/FIFO and the memory interconnect; the DMA writer drains the same FIFO downstream.

Parameters:
- MAX_BURST, 32, largest accepted word count per transfer; must be 1..256.

Ports:
- i_wire_clock  in  1  system clock
- i_wire_resetn  in  1  asynchronous, active-low global reset
- i_wire_ctrl_resetn  in  1  transfer control: low = abort/idle, high = run one transfer
- i_wire_address  in  32  byte start address, sampled at start
- i_wire_length  in  32  word count, sampled at start
- o_wire_done  out  1  transfer completed OK; held until ctrl_resetn low
- o_wire_error  out  1  transfer failed; held until ctrl_resetn low
- o_wire_axi_araddr  out  32  AR address
- o_wire_axi_arlen  out  8  beats-1
- o_wire_axi_arsize  out  3  constant 3'b010
- o_wire_axi_arburst  out  2  constant 2'b01 (INCR)
- o_wire_axi_arvalid  out  1
- i_wire_axi_arready  in  1
- i_wire_axi_rdata  in  32
- i_wire_axi_rresp  in  2
- i_wire_axi_rlast  in  1
- i_wire_axi_rvalid  in  1
- o_wire_axi_rready  out  1
- o_wire_fifo_wdata  out  32  word to FIFO
- o_wire_fifo_wen  out  1  FIFO write strobe, one word per cycle
- i_wire_fifo_full  in  1  FIFO cannot accept a word this cycle

Behaviour:
- Global reset: state IDLE; all outputs 0 except the constant arsize/arburst; internal registers 0.
- IDLE: leave when ctrl_resetn=1.
  - Latch address/length; go to CHECK.
  - Latched length 0 -> DONE.
- CHECK (1 cycle), checks evaluated in this order:
  - length>MAX_BURST -> ERROR
  - address[1:0]!=0 -> ERROR
  - address[11:0]+length*4 >4096 (13-bit compare; 4 KB crossing) -> ERROR
  - otherwise -> ADDR
- ADDR:
  - arvalid=1, araddr=latched address, arlen=length-1 (8 bits).
  - arvalid stays high and stable until arready; on handshake -> DATA.
- DATA:
  - rready = !fifo_full (combinational).
  - Each rvalid&&rready beat: fifo_wen=1 and fifo_wdata=rdata in the same cycle; beat counter +1.
  - Beat with rresp!=0: set sticky resp_err and still push the beat.
  - rlast on beat N=length:
    - resp_err set -> ERROR
    - otherwise -> DONE
  - Protocol errors, both -> ERROR:
    - rlast before beat N (count mismatch).
    - Beat N without rlast; set a flag, remain in DATA with rready=1 and no further FIFO writes until rlast, then go to ERROR.
- DONE: done=1. ERROR: error=1. Both flags are registered, so they assert 1 cycle after the final beat.
- Latency, AR handshake to first possible FIFO write: 0 cycles from R beat. Start to arvalid: 2 cycles (IDLE->CHECK->ADDR).
- ctrl_resetn low:
  - IDLE/CHECK/DONE/ERROR -> IDLE next cycle; done/error clear that cycle.
  - ADDR/DATA -> FLUSH; done/error stay 0.
- FLUSH, which keeps the AXI protocol legal:
  - Keep arvalid until handshake if not yet accepted.
  - Then rready=1, discard beats (fifo_wen=0) until rlast, then IDLE.
  - A start (ctrl_resetn=1) during FLUSH is ignored until IDLE is reached.
- fifo_wen is never asserted while fifo_full=1, or in FLUSH, CHECK, ADDR, DONE, ERROR.
- Global reset mid-transfer is immediate; interconnect reset is the system's responsibility.

Decomposition:
- Shared package gpu_dma_pkg:
  - state encodings IDLE=0, CHECK=1, ADDR=2, DATA=3, DONE=4, ERROR=5, FLUSH=6
  - AXI constants: SIZE_4B, BURST_INCR, RESP_OKAY
  - 4 KB boundary constant
  - The DMA writer reuses this package.
- No sub-module; a single FSM plus beat counter.

Test Plan:
- addr 0x1000_0000, len 32, slave zero wait, data=index:
  - arlen=31; 32 fifo_wen pulses with data 0..31; done=1 one cycle after beat 32.
  - done held until ctrl_resetn=0, cleared the next cycle.
- len 8, fifo_full toggling every other cycle:
  - rready tracks !full; exactly 8 writes, none while full; done asserted.
- Input checks:
  - len 33 -> error, no arvalid.
  - addr 0x1002 -> error.
  - addr 0x0FF0 len 8 (crosses 4 KB) -> error.
  - len 0 -> done, no arvalid.
- len 4, beat 2 rresp=2'b10 -> all 4 beats written; error=1, done=0.
- len 4, slave asserts rlast on beat 3 -> error.
- len 16, ctrl_resetn dropped after 5 beats:
  - Remaining 11 beats accepted with no FIFO writes; returns to IDLE.
  - A new start then behaves normally.
